// File: rtl/r22sdf_twiddle_mult.sv
`default_nettype none
// ============================================================================
// Module   : r22sdf_twiddle_mult
// Purpose  : R2^2SDF inter-stage twiddle multiplier with a 4-stage pipeline.
//            Optional macro R22SDF_TWIDDLE_ROUND_EN selects round-half-up
//            scaling; when it is not defined, scaling truncates.
// Revision : 1.0 - initial release
// ============================================================================
module r22sdf_twiddle_mult #(
   parameter int DIN_WIDTH     = 17,
   parameter int TWIDDLE_WIDTH = 16,
   parameter int FFT_SIZE      = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [DIN_WIDTH-1:0] din_re,
   input  logic signed [DIN_WIDTH-1:0] din_im,
   input  logic                        din_valid,
   input  logic                        sync_in,
   output logic signed [DIN_WIDTH:0]   dout_re,
   output logic signed [DIN_WIDTH:0]   dout_im,
   output logic                        dout_valid,
   output logic                        dout_sync
);

   localparam int  CW        = $clog2(FFT_SIZE);
   localparam int  ROM_DEPTH = 3 * FFT_SIZE / 4;
   localparam int  PW        = DIN_WIDTH + TWIDDLE_WIDTH;
   localparam int  SW        = PW + 1;
   localparam int  OW        = DIN_WIDTH + 1;
   localparam int  SHIFT     = TWIDDLE_WIDTH - 1;
   localparam real PI        = 3.14159265358979323846;

   // Elaboration-time cos/-sin in Q1.(TWIDDLE_WIDTH-1), via range-reduced Taylor series.
   function automatic int tw_value(input int idx, input bit imag);
      real theta;
      real x2;
      real term;
      real acc;
      real full;
      real scaled;
      int  r;
      theta = 2.0 * PI * real'(idx) / real'(FFT_SIZE);
      if (theta > PI) theta = theta - 2.0 * PI;
      x2 = theta * theta;
      if (imag) begin
         term = theta;
         acc  = theta;
         for (int k = 1; k < 24; k++) begin
            term = -term * x2 / real'((2 * k) * (2 * k + 1));
            acc  = acc + term;
         end
         acc = -acc;
      end else begin
         term = 1.0;
         acc  = 1.0;
         for (int k = 1; k < 24; k++) begin
            term = -term * x2 / real'((2 * k - 1) * (2 * k));
            acc  = acc + term;
         end
      end
      full = 1.0;
      for (int k = 0; k < SHIFT; k++) full = full * 2.0;
      scaled = acc * full;
      if (scaled >= 0.0) r = $rtoi(scaled + 0.5);
      else               r = -$rtoi(0.5 - scaled);
      if (r > (2 ** SHIFT) - 1) r = (2 ** SHIFT) - 1;
      return r;
   endfunction

   logic signed [TWIDDLE_WIDTH-1:0] rom_re [ROM_DEPTH];
   logic signed [TWIDDLE_WIDTH-1:0] rom_im [ROM_DEPTH];

   for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
      localparam int RE_V = tw_value(i, 1'b0);
      localparam int IM_V = tw_value(i, 1'b1);
      assign rom_re[i] = TWIDDLE_WIDTH'(RE_V);
      assign rom_im[i] = TWIDDLE_WIDTH'(IM_V);
   end

   logic [CW-1:0] cnt;
   logic [CW-1:0] n_cur;
   logic [1:0]    quad;
   logic [CW-1:0] m_ext;
   logic [CW-1:0] expo;

   // Sync forces this sample to index 0, so the ROM address never waits on the counter.
   always_comb begin
      n_cur = sync_in ? '0 : cnt;
      quad  = n_cur[CW-1 -: 2];
      m_ext = {2'b00, n_cur[CW-3:0]};
      case (quad)
         2'd0:    expo = '0;
         2'd1:    expo = m_ext << 1;
         2'd2:    expo = m_ext;
         default: expo = m_ext + (m_ext << 1);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (din_valid) begin
         if (sync_in)                       cnt <= CW'(1);
         else if (cnt == CW'(FFT_SIZE - 1)) cnt <= '0;
         else                               cnt <= cnt + CW'(1);
      end
   end

   logic                        v1, v2, v3;
   logic                        sy1, sy2, sy3;
   logic signed [DIN_WIDTH-1:0] a1, b1;
   logic signed [TWIDDLE_WIDTH-1:0] c1, d1;
   logic signed [PW-1:0]        p_ac, p_bd, p_ad, p_bc;
   logic signed [SW-1:0]        s_re, s_im;
   logic signed [SW-1:0]        r_re, r_im;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1  <= 1'b0;
         v2  <= 1'b0;
         v3  <= 1'b0;
         sy1 <= 1'b0;
         sy2 <= 1'b0;
         sy3 <= 1'b0;
      end else begin
         v1  <= din_valid;
         v2  <= v1;
         v3  <= v2;
         sy1 <= din_valid & sync_in;
         sy2 <= sy1;
         sy3 <= sy2;
      end
   end

   always_ff @(posedge clk) begin
      a1   <= din_re;
      b1   <= din_im;
      c1   <= rom_re[expo];
      d1   <= rom_im[expo];
      p_ac <= PW'(a1) * PW'(c1);
      p_bd <= PW'(b1) * PW'(d1);
      p_ad <= PW'(a1) * PW'(d1);
      p_bc <= PW'(b1) * PW'(c1);
      s_re <= SW'(p_ac) - SW'(p_bd);
      s_im <= SW'(p_ad) + SW'(p_bc);
   end

`ifdef R22SDF_TWIDDLE_ROUND_EN
   localparam logic signed [SW-1:0] RND = SW'(64'sd1 <<< (SHIFT - 1));
   always_comb begin
      r_re = s_re + RND;
      r_im = s_im + RND;
   end
`else
   always_comb begin
      r_re = s_re;
      r_im = s_im;
   end
`endif

   // Output data holds between valid samples; the result always fits OW bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_re    <= '0;
         dout_im    <= '0;
         dout_valid <= 1'b0;
         dout_sync  <= 1'b0;
      end else begin
         dout_valid <= v3;
         dout_sync  <= sy3;
         if (v3) begin
            dout_re <= OW'(r_re >>> SHIFT);
            dout_im <= OW'(r_im >>> SHIFT);
         end
      end
   end

endmodule
`default_nettype wire
